seq_gen: RTL and testbench
==========================

// Module: seq_gen
// PURPOSE
//  Serial pattern transmitter: emits a fixed PAT_W-bit pattern (default 1101) MSB-first on a 1-bit line.
//  Sends a programmable number of frames, with a programmable idle gap between frames.
//  Stimulus/transmit side of the serial sequence-detector path; its o output drives a detector's i input.
//  Start/busy/done handshake and synchronous abort.
// PARAMETERS
//  PAT_W    4        pattern length in bits (>=2)
//  PATTERN  4'b1101  pattern bits; bit PAT_W-1 is sent first
//  GAP_W    4        width of gap length input
//  CNT_W    8        width of frame-count input
// PORTS
//  clk       in   1      clock, rising-edge
//  rst       in   1      reset, asynchronous, active-low
//  start     in   1      request a transmission; sampled only in IDLE
//  repeat_n  in   CNT_W  number of frames to send; latched on accepted start
//  gap       in   GAP_W  idle cycles between frames; latched on accepted start
//  abort     in   1      synchronous cancel, any state
//  o         out  1      serial data bit, registered
//  o_vld     out  1      o carries a pattern bit this cycle
//  busy      out  1      transmission in progress (SEND or GAP)
//  done      out  1      one-cycle pulse after the last bit of the last frame
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; o=0, o_vld=0, busy=0, done=0; all counters cleared.
//  States: IDLE, SEND, GAP, DONE. All outputs registered; every transition occurs on a rising clk edge.
//  IDLE:
//   - On start=1: latch repeat_n to frm_left and gap to gap_len.
//   - If repeat_n==0: go to DONE (no bits sent).
//   - Else: go to SEND with bit_idx=PAT_W-1. The first bit is visible 1 cycle after the start edge.
//  SEND:
//   - o=PATTERN[bit_idx], o_vld=1, busy=1; bit_idx decrements each cycle.
//   - At bit_idx==0:
//     - frm_left==1 -> DONE.
//     - Else frm_left-=1; then gap_len==0 -> stay in SEND (bit_idx=PAT_W-1, back-to-back frames), else -> GAP.
//  GAP:
//   - o=0, o_vld=0, busy=1 for exactly gap_len cycles, then SEND with bit_idx=PAT_W-1.
//  DONE:
//   - done=1, busy=0, o=0, o_vld=0 for one cycle, then IDLE.
//  Frame timing: a frame occupies PAT_W consecutive o_vld cycles.
//   - Total busy cycles = repeat_n*PAT_W + (repeat_n-1)*gap.
//  Handshake rules:
//   - start is ignored unless the state is IDLE; it is not queued.
//   - start asserted in the same cycle that DONE is active is ignored; it is accepted the next cycle.
//   - repeat_n and gap changes after acceptance have no effect.
//  abort=1 (any state, including a simultaneous start in IDLE):
//   - Next state is IDLE; o=0, o_vld=0, busy=0.
//   - done is NOT pulsed; counters are cleared.
//   - abort has priority over start and over all other transitions.
//  Width rules:
//   - frm_left is CNT_W bits; gap counter is GAP_W bits; bit_idx is $clog2(PAT_W) bits.
//   - No wrap-around: repeat_n=2^CNT_W-1 sends exactly that many frames.
//  Reset mid-transmission: immediate return to reset values; no done pulse.
// TESTING
//  T1 reset: hold rst=0 with toggling start -> o, o_vld, busy, done all remain 0.
//  T2 single frame: repeat_n=1, gap=0, start for 1 cycle -> o=1,1,0,1 with o_vld=1 on cycles 1..4
//     after start; done=1 on cycle 5; busy=1 on cycles 1..4.
//  T3 gap: repeat_n=2, gap=3 -> 1101, 3 cycles of o_vld=0, 1101; done on cycle 12.
//  T4 loopback: o -> detector input, repeat_n=3, gap=0 -> detector flags exactly 3 pattern hits.
//  T5 abort: repeat_n=5, gap=1; abort on 2nd bit of frame 2 -> idle next cycle; no done pulse;
//     a new start is then accepted normally.
//  T6 corners: repeat_n=0 -> done pulse 1 cycle after start with o_vld never set;
//     start held high through a run -> ignored while busy; a new run is accepted 1 cycle after done.

Source files
------------

// File: rtl/seq_gen_if.sv
// Control and serial-output bundle for the seq_gen pattern transmitter.
//
// Handshake: start is a level request that the transmitter samples only while
// idle. A request is accepted on the rising edge where start=1 and the block
// is idle. repeat_n and gap are captured on that same edge. busy then stays high
// until the run ends. done pulses for one cycle after the last bit of a
// completed run. abort cancels a run on the next edge without a done pulse.
// o is meaningful only while o_vld=1.
interface seq_gen_if #(
  parameter int GAP_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             o;
  logic             o_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_n, gap, abort,
    input  o, o_vld, busy, done
  );

  modport slave (
    input  start, repeat_n, gap, abort,
    output o, o_vld, busy, done
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter. It sends PATTERN MSB-first for a latched number
// of frames and inserts a latched number of idle cycles between frames.
// All outputs are registered and are decoded from the next state, so the first
// bit appears in the cycle right after the start edge.
module seq_gen #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int             GAP_W   = 4,
  parameter int             CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_gen_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    bit_idx, bit_idx_n;
  logic [CNT_W-1:0] frm_left, frm_left_n;
  logic [GAP_W-1:0] gap_len, gap_len_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             o_n, o_vld_n, busy_n, done_n;

  assign dbg_state = state;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      frm_left <= '0;
      gap_len  <= '0;
      gap_cnt  <= '0;
      bus.o     <= 1'b0;
      bus.o_vld <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      state    <= state_n;
      bit_idx  <= bit_idx_n;
      frm_left <= frm_left_n;
      gap_len  <= gap_len_n;
      gap_cnt  <= gap_cnt_n;
      bus.o     <= o_n;
      bus.o_vld <= o_vld_n;
      bus.busy  <= busy_n;
      bus.done  <= done_n;
    end
  end

  // Next-state and counter updates; abort overrides every transition.
  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    frm_left_n = frm_left;
    gap_len_n  = gap_len;
    gap_cnt_n  = gap_cnt;

    case (state)
      IDLE: begin
        if (bus.start) begin
          frm_left_n = bus.repeat_n;
          gap_len_n  = bus.gap;
          bit_idx_n  = LAST_IDX;
          if (bus.repeat_n == '0) state_n = DONE;
          else                    state_n = SEND;
        end
      end
      SEND: begin
        if (bit_idx == '0) begin
          if (frm_left == CNT_W'(1)) begin
            state_n    = DONE;
            frm_left_n = '0;
          end else begin
            frm_left_n = frm_left - CNT_W'(1);
            bit_idx_n  = LAST_IDX;
            if (gap_len != '0) begin
              state_n   = GAP;
              gap_cnt_n = gap_len - GAP_W'(1);
            end
          end
        end else begin
          bit_idx_n = bit_idx - IW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n   = SEND;
          bit_idx_n = LAST_IDX;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      DONE: begin
        state_n    = IDLE;
        bit_idx_n  = '0;
        frm_left_n = '0;
        gap_len_n  = '0;
        gap_cnt_n  = '0;
      end
      default: state_n = IDLE;
    endcase

    if (bus.abort) begin
      state_n    = IDLE;
      bit_idx_n  = '0;
      frm_left_n = '0;
      gap_len_n  = '0;
      gap_cnt_n  = '0;
    end
  end

  // Output decode from the next state, registered above.
  always_comb begin
    o_vld_n = (state_n == SEND);
    o_n     = o_vld_n ? PATTERN[bit_idx_n] : 1'b0;
    busy_n  = (state_n == SEND) || (state_n == GAP);
    done_n  = (state_n == DONE);
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: cycle tables of {inputs, expected outputs} plus
// hand-written reset, loopback, mid-run reset and maximum-count sequences.
module tb_seq_gen;
  localparam int PAT_W = 4;
  localparam int GAP_W = 4;
  localparam int CNT_W = 8;
  localparam logic [PAT_W-1:0] PAT = 4'b1101;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_gen_if #(.GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();
  logic [1:0] dbg_state;

  seq_gen #(.PAT_W(PAT_W), .PATTERN(PAT), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  typedef struct {
    string      name;
    logic       start;
    logic [7:0] rep;
    logic [3:0] gap;
    logic       abort;
    logic [3:0] exp;   // {o, o_vld, busy, done} after the edge
  } vec_t;

  vec_t vecs[$];
  logic [0:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic void add(string n, logic s, logic [7:0] r, logic [3:0] g,
                              logic a, logic [3:0] e);
    vec_t v;
    v.name = n; v.start = s; v.rep = r; v.gap = g; v.abort = a; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.o, bus.o_vld, bus.busy, bus.done};
  endfunction

  // driver tasks
  task automatic drive(logic s, logic [7:0] r, logic [3:0] g, logic a);
    bus.start = s; bus.repeat_n = r; bus.gap = g; bus.abort = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] sr;
    int hits, n, vld_cnt, busy_cnt;

    // T2 single frame
    add("t2", 1, 1, 0, 0, 4'b1110);
    add("t2", 0, 1, 0, 0, 4'b1110);
    add("t2", 0, 1, 0, 0, 4'b0110);
    add("t2", 0, 1, 0, 0, 4'b1110);
    add("t2", 0, 1, 0, 0, 4'b0001);
    add("t2", 0, 1, 0, 0, 4'b0000);
    // T3 two frames with a 3-cycle gap; done on cycle 12
    add("t3", 1, 2, 3, 0, 4'b1110);
    add("t3", 0, 0, 0, 0, 4'b1110);
    add("t3", 0, 0, 0, 0, 4'b0110);
    add("t3", 0, 0, 0, 0, 4'b1110);
    for (int i = 0; i < 3; i++) add("t3gap", 0, 0, 0, 0, 4'b0010);
    add("t3", 0, 0, 0, 0, 4'b1110);
    add("t3", 0, 0, 0, 0, 4'b1110);
    add("t3", 0, 0, 0, 0, 4'b0110);
    add("t3", 0, 0, 0, 0, 4'b1110);
    add("t3", 0, 0, 0, 0, 4'b0001);
    add("t3", 0, 0, 0, 0, 4'b0000);
    // T6 repeat_n=0
    add("t6zero", 1, 0, 5, 0, 4'b0001);
    add("t6zero", 0, 0, 0, 0, 4'b0000);
    // T6 start held through a run; repeat_n changes mid-run are ignored
    add("t6held", 1, 1, 0, 0, 4'b1110);
    add("t6held", 1, 3, 2, 0, 4'b1110);
    add("t6held", 1, 3, 2, 0, 4'b0110);
    add("t6held", 1, 3, 2, 0, 4'b1110);
    add("t6held", 1, 3, 2, 0, 4'b0001);
    add("t6held", 1, 3, 2, 0, 4'b0000);
    add("t6held", 1, 1, 0, 0, 4'b1110);
    add("t6held", 0, 1, 0, 0, 4'b1110);
    add("t6held", 0, 1, 0, 0, 4'b0110);
    add("t6held", 0, 1, 0, 0, 4'b1110);
    add("t6held", 0, 1, 0, 0, 4'b0001);
    add("t6held", 0, 1, 0, 0, 4'b0000);
    // T5 abort on 2nd bit of frame 2, then a normal run
    add("t5", 1, 5, 1, 0, 4'b1110);
    add("t5", 0, 0, 0, 0, 4'b1110);
    add("t5", 0, 0, 0, 0, 4'b0110);
    add("t5", 0, 0, 0, 0, 4'b1110);
    add("t5gap", 0, 0, 0, 0, 4'b0010);
    add("t5", 0, 0, 0, 0, 4'b1110);
    add("t5", 0, 0, 0, 0, 4'b1110);
    add("t5abort", 0, 0, 0, 1, 4'b0000);
    add("t5nodone", 0, 0, 0, 0, 4'b0000);
    add("t5restart", 1, 1, 0, 0, 4'b1110);
    add("t5restart", 0, 0, 0, 0, 4'b1110);
    add("t5restart", 0, 0, 0, 0, 4'b0110);
    add("t5restart", 0, 0, 0, 0, 4'b1110);
    add("t5restart", 0, 0, 0, 0, 4'b0001);
    add("t5restart", 0, 0, 0, 0, 4'b0000);
    // abort wins over a simultaneous start
    add("abort_start", 1, 1, 0, 1, 4'b0000);
    add("abort_start", 0, 1, 0, 0, 4'b0000);
    // abort during a gap
    add("abort_gap", 1, 2, 2, 0, 4'b1110);
    add("abort_gap", 0, 2, 2, 0, 4'b1110);
    add("abort_gap", 0, 2, 2, 0, 4'b0110);
    add("abort_gap", 0, 2, 2, 0, 4'b1110);
    add("abort_gap", 0, 2, 2, 0, 4'b0010);
    add("abort_gap", 0, 2, 2, 1, 4'b0000);
    add("abort_gap", 0, 2, 2, 0, 4'b0000);

    // T1 reset held with toggling start
    rst = 1'b0;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      bus.start = i[0];
      step();
      chk($sformatf("t1_reset[%0d]", i), {28'd0, outs()}, 32'd0);
    end
    chk("t1_state", {30'd0, dbg_state}, 32'd0);
    bus.start = 1'b0;
    rst = 1'b1;
    step();
    chk("t1_idle", {28'd0, outs()}, 32'd0);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].rep, vecs[i].gap, vecs[i].abort);
      step();
      chk($sformatf("%s[%0d]", vecs[i].name, i), {28'd0, outs()}, {28'd0, vecs[i].exp});
    end
    drive(0, 0, 0, 0);
    step();

    // T4 loopback into a 1101 detector model, with an expected-bit scoreboard
    for (int f = 0; f < 3; f++)
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(PAT[b]);
    sr = '0; hits = 0; n = 0;
    drive(1, 3, 0, 0);
    do begin
      step();
      bus.start = 1'b0;
      sr = {sr[2:0], bus.o};
      if (sr == PAT) hits++;
      if (bus.o_vld) begin
        if (exp_q.size() == 0) chk("t4_extra_bit", 32'd1, 32'd0);
        else chk("t4_bit", {31'd0, bus.o}, {31'd0, exp_q.pop_front()});
      end
      n++;
    end while (!bus.done && n < 40);
    chk("t4_done", {31'd0, bus.done}, 32'd1);
    chk("t4_hits", hits, 3);
    chk("t4_queue_left", exp_q.size(), 0);
    step();

    // reset mid-transmission: immediate clear, no done pulse afterwards
    drive(1, 3, 0, 0);
    step();
    bus.start = 1'b0;
    step();
    chk("midrst_running", {31'd0, bus.o_vld}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_async", {28'd0, outs()}, 32'd0);
    chk("midrst_state", {30'd0, dbg_state}, 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("midrst_quiet[%0d]", i), {28'd0, outs()}, 32'd0);
    end

    // maximum frame count: 255 frames, gap 1, counted to done
    vld_cnt = 0; busy_cnt = 0; n = 0;
    drive(1, 8'd255, 4'd1, 0);
    do begin
      step();
      bus.start = 1'b0;
      if (bus.o_vld) vld_cnt++;
      if (bus.busy) busy_cnt++;
      n++;
    end while (!bus.done && n < 2000);
    chk("max_done", {31'd0, bus.done}, 32'd1);
    chk("max_vld_cycles", vld_cnt, 255 * PAT_W);
    chk("max_busy_cycles", busy_cnt, 255 * PAT_W + 254);
    step();
    chk("max_idle", {28'd0, outs()}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
